// File: rtl/mux4x1_ins_sel.sv
`default_nettype none
// ============================================================================
//  Module   : mux4x1_ins_sel
//  Purpose  : Instruction-word selector for the instruction cache datapath.
//             Picks one of the four words of a 128-bit cache block using the
//             word offset (PC[3:2]). The combinational result (muxout) feeds
//             the cache hit logic. The registered, valid-qualified copy
//             (ins_out/out_offset/out_valid) feeds the fetch pipeline.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH       width of each instruction word (default 32)
//  Ports
//    clock       in   1      rising-edge clock
//    reset       in   1      asynchronous, active-high reset
//    ins1..ins4  in   WIDTH  block words 0..3 (bits [31:0] .. [127:96])
//    offset      in   2      word select
//    in_valid    in   1      capture request for the registered stage
//    muxout      out  WIDTH  combinational selected word
//    ins_out     out  WIDTH  registered selected word
//    out_offset  out  2      offset captured with ins_out
//    out_valid   out  1      ins_out was captured on the previous edge
//    out_parity  out  1      even parity (XOR reduction) of ins_out
//                            (present only with MUX4X1_INS_PARITY_EN)
//  Build option
//    MUX4X1_INS_PARITY_EN  adds the registered out_parity output
// ============================================================================
module mux4x1_ins_sel #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] ins1,
    input  logic [WIDTH-1:0] ins2,
    input  logic [WIDTH-1:0] ins3,
    input  logic [WIDTH-1:0] ins4,
    input  logic [1:0]       offset,
    input  logic             in_valid,
    output logic [WIDTH-1:0] muxout,
    output logic [WIDTH-1:0] ins_out,
    output logic [1:0]       out_offset,
`ifdef MUX4X1_INS_PARITY_EN
    output logic             out_parity,
`endif
    output logic             out_valid
);

    // ------------------------------------------------------------------
    // Combinational select. It is not gated by reset or in_valid, so the
    // hit logic always sees the addressed word. An unknown offset drives
    // all-X in simulation; synthesis is free to treat it as don't-care.
    // ------------------------------------------------------------------
    always_comb begin
        muxout = {WIDTH{1'bx}};
        case (offset)
            2'b00:   muxout = ins1;
            2'b01:   muxout = ins2;
            2'b10:   muxout = ins3;
            2'b11:   muxout = ins4;
            default: muxout = {WIDTH{1'bx}};
        endcase
    end

    // ------------------------------------------------------------------
    // Output registers. The word and offset load only on a capture and
    // hold otherwise. The valid flag follows in_valid on every edge.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] ins_q,    ins_d;
    logic [1:0]       offset_q, offset_d;
    logic             valid_q,  valid_d;

    always_comb begin
        ins_d    = ins_q;
        offset_d = offset_q;
        valid_d  = in_valid;
        if (in_valid) begin
            ins_d    = muxout;
            offset_d = offset;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ins_q    <= '0;
            offset_q <= 2'b00;
            valid_q  <= 1'b0;
        end else begin
            ins_q    <= ins_d;
            offset_q <= offset_d;
            valid_q  <= valid_d;
        end
    end

    assign ins_out    = ins_q;
    assign out_offset = offset_q;
    assign out_valid  = valid_q;

`ifdef MUX4X1_INS_PARITY_EN
    // Parity is computed from the word being loaded, so it lines up with
    // ins_out in the same cycle and holds whenever ins_out holds.
    logic parity_q, parity_d;

    always_comb begin
        parity_d = parity_q;
        if (in_valid) begin
            parity_d = ^muxout;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign out_parity = parity_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux4x1_ins_sel.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux4x1_ins_sel
//  Purpose  : Directed self-checking bench for mux4x1_ins_sel.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mux4x1_ins_sel;

    localparam int WIDTH = 32;

    logic             clock;
    logic             reset;
    logic [WIDTH-1:0] ins1, ins2, ins3, ins4;
    logic [1:0]       offset;
    logic             in_valid;
    logic [WIDTH-1:0] muxout;
    logic [WIDTH-1:0] ins_out;
    logic [1:0]       out_offset;
    logic             out_valid;
`ifdef MUX4X1_INS_PARITY_EN
    logic             out_parity;
`endif

    int n_cmp;
    int n_err;

    mux4x1_ins_sel #(.WIDTH(WIDTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .ins1       (ins1),
        .ins2       (ins2),
        .ins3       (ins3),
        .ins4       (ins4),
        .offset     (offset),
        .in_valid   (in_valid),
        .muxout     (muxout),
        .ins_out    (ins_out),
        .out_offset (out_offset),
`ifdef MUX4X1_INS_PARITY_EN
        .out_parity (out_parity),
`endif
        .out_valid  (out_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Drive on the falling edge, then sample 1 time unit after the next rising edge.
    task automatic cap_cycle(input logic [1:0] off, input logic vld);
        @(negedge clock);
        offset   = off;
        in_valid = vld;
        @(posedge clock);
        #1;
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        reset    = 1'b1;
        in_valid = 1'b0;
        offset   = 2'b00;
        ins1     = 32'h11111111;
        ins2     = 32'h22222222;
        ins3     = 32'h33333333;
        ins4     = 32'h44444444;

        // Reset state; combinational path live during reset
        #2;
        check("rst_ins_out", ins_out, 32'h0);
        check("rst_out_off", {30'd0, out_offset}, 32'h0);
        check("rst_out_vld", {31'd0, out_valid}, 32'h0);
        check("rst_muxout",  muxout, 32'h11111111);
`ifdef MUX4X1_INS_PARITY_EN
        check("rst_parity", {31'd0, out_parity}, 32'h0);
`endif

        @(negedge clock);
        reset = 1'b0;

        // Combinational sweep
        offset = 2'd0; #1 check("mux_off0", muxout, 32'h11111111);
        offset = 2'd1; #1 check("mux_off1", muxout, 32'h22222222);
        offset = 2'd2; #1 check("mux_off2", muxout, 32'h33333333);
        offset = 2'd3; #1 check("mux_off3", muxout, 32'h44444444);
        check("idle_vld", {31'd0, out_valid}, 32'h0);

        // Single capture then hold
        cap_cycle(2'd2, 1'b1);
        check("cap_ins",  ins_out, 32'h33333333);
        check("cap_off",  {30'd0, out_offset}, 32'h2);
        check("cap_vld",  {31'd0, out_valid}, 32'h1);
        cap_cycle(2'd0, 1'b0);
        check("hold_vld", {31'd0, out_valid}, 32'h0);
        check("hold_ins", ins_out, 32'h33333333);
        check("hold_off", {30'd0, out_offset}, 32'h2);

        // Back-to-back captures
        cap_cycle(2'd3, 1'b1);
        check("b2b0_ins", ins_out, 32'h44444444);
        check("b2b0_vld", {31'd0, out_valid}, 32'h1);
        cap_cycle(2'd0, 1'b1);
        check("b2b1_ins", ins_out, 32'h11111111);
        check("b2b1_vld", {31'd0, out_valid}, 32'h1);
        cap_cycle(2'd1, 1'b1);
        check("b2b2_ins", ins_out, 32'h22222222);
        check("b2b2_off", {30'd0, out_offset}, 32'h1);
        check("b2b2_vld", {31'd0, out_valid}, 32'h1);

        // Asynchronous reset mid-stream, between edges
        @(negedge clock);
        #1 reset = 1'b1;
        #1;
        check("arst_ins", ins_out, 32'h0);
        check("arst_off", {30'd0, out_offset}, 32'h0);
        check("arst_vld", {31'd0, out_valid}, 32'h0);
        offset = 2'd3;
        #1 check("arst_mux", muxout, 32'h44444444);
        // Edge with reset held and in_valid high must not capture
        @(posedge clock);
        #1 check("rsthold_vld", {31'd0, out_valid}, 32'h0);

        // First capture after release
        @(negedge clock);
        offset = 2'd2;
        reset  = 1'b0;
        @(posedge clock);
        #1;
        check("rel_ins", ins_out, 32'h33333333);
        check("rel_vld", {31'd0, out_valid}, 32'h1);

        // Input change right after an edge: the sampled value is the stored one
        cap_cycle(2'd0, 1'b1);
        offset = 2'd3;
        ins1   = 32'hA5A5A5A5;
        #1;
        check("samp_ins", ins_out, 32'h11111111);
        check("samp_off", {30'd0, out_offset}, 32'h0);

        // Zero-latency update of a data input
        in_valid = 1'b0;
        offset   = 2'd1;
        ins2     = 32'hDEADBEEF;
        #1 check("live_mux", muxout, 32'hDEADBEEF);

`ifdef MUX4X1_INS_PARITY_EN
        ins1 = 32'h00000007;
        ins2 = 32'h00000003;
        cap_cycle(2'd0, 1'b1);
        check("par_7", {31'd0, out_parity}, 32'h1);
        cap_cycle(2'd1, 1'b1);
        check("par_3", {31'd0, out_parity}, 32'h0);
        cap_cycle(2'd0, 1'b0);
        check("par_hold", {31'd0, out_parity}, 32'h0);
        cap_cycle(2'd0, 1'b1);
        cap_cycle(2'd1, 1'b0);
        check("par_hold1", {31'd0, out_parity}, 32'h1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
